pong_scoreboard: RTL and testbench

//  Keeps the two player scores for the ping-pong game in BCD and declares the winner.

---
 rtl/pong_scoreboard.sv | 178 +++++++++++++++++
 tb/tb_pong_scoreboard.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pong_scoreboard.sv
// Ping-pong BCD scoreboard with winner detection and a 4-digit multiplexed seven-segment display.
// Optional build macro SCORE_BLANK_LZ_EN blanks a tens digit that is zero.
module pong_scoreboard #(
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       scan_clk,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       new_game,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = 2 * DIGIT_W;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned SEG_W   = 7;
  localparam logic [SCORE_W-1:0] WIN_BCD = {DIGIT_W'(WIN_SCORE / 10), DIGIT_W'(WIN_SCORE % 10)};

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic [SCORE_W-1:0]   p1_inc, p2_inc;
  logic                 winner_q, winner_d;
  logic                 game_over_q, game_over_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           an_q, an_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 s1_q, s2_q, s3_q;
  logic                 scan_tick;
  logic [DIGIT_W-1:0]   digit;
  logic                 digit_is_tens;

  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [DIGIT_W-1:0] tens, ones;
    tens = v[SCORE_W-1:DIGIT_W];
    ones = v[DIGIT_W-1:0];
    if (ones == DIGIT_W'(9)) begin
      ones = '0;
      tens = (tens == DIGIT_W'(9)) ? '0 : tens + DIGIT_W'(1);
    end else begin
      ones = ones + DIGIT_W'(1);
    end
    return {tens, ones};
  endfunction

  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // scan_clk is only a tick source: synchronise and detect its rising edge
  assign scan_tick = s2_q & ~s3_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= PLAY;
      p1_q        <= '0;
      p2_q        <= '0;
      winner_q    <= 1'b0;
      game_over_q <= 1'b0;
      idx_q       <= '0;
      an_q        <= 4'b1110;
      seg_q       <= 7'b0000001;
      dp_q        <= 1'b1;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      s1_q        <= scan_clk;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    winner_d      = winner_q;
    game_over_d   = game_over_q;
    idx_d         = idx_q;
    p1_inc        = bcd_inc(p1_q);
    p2_inc        = bcd_inc(p2_q);
    digit         = '0;
    digit_is_tens = 1'b0;

    if (scan_tick) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (new_game) begin
      state_d     = PLAY;
      p1_d        = '0;
      p2_d        = '0;
      winner_d    = 1'b0;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          // simultaneous points cancel out
          if (point_p1 && !point_p2) begin
            p1_d = p1_inc;
            if (p1_inc == WIN_BCD) begin
              state_d     = OVER;
              winner_d    = 1'b0;
              game_over_d = 1'b1;
            end
          end else if (point_p2 && !point_p1) begin
            p2_d = p2_inc;
            if (p2_inc == WIN_BCD) begin
              state_d     = OVER;
              winner_d    = 1'b1;
              game_over_d = 1'b1;
            end
          end
        end
        OVER: begin
        end
        default: state_d = PLAY;
      endcase
    end

    case (idx_q)
      2'd3:    begin digit = p1_q[SCORE_W-1:DIGIT_W]; digit_is_tens = 1'b1; end
      2'd2:    digit = p1_q[DIGIT_W-1:0];
      2'd1:    begin digit = p2_q[SCORE_W-1:DIGIT_W]; digit_is_tens = 1'b1; end
      default: digit = p2_q[DIGIT_W-1:0];
    endcase

    an_d  = ~(4'b0001 << idx_q);
    dp_d  = (idx_q != 2'd2);
    seg_d = seg_decode(digit);
`ifdef SCORE_BLANK_LZ_EN
    if (digit_is_tens && digit == '0) begin
      seg_d = 7'b1111111;
    end
`else
    if (digit_is_tens) begin
      seg_d = seg_decode(digit);
    end
`endif
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_scoreboard.sv
// Directed, table-driven bench for pong_scoreboard (WIN_SCORE = 11), scores observed via the scanned display.
module tb_pong_scoreboard;

  logic       mclk = 1'b0;
  logic       rst, scan_clk, point_p1, point_p2, new_game;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, game_over, winner;

  int pass_cnt = 0;
  int total    = 0;

  pong_scoreboard #(.WIN_SCORE(11)) dut (
    .mclk(mclk), .rst(rst), .scan_clk(scan_clk), .point_p1(point_p1), .point_p2(point_p2),
    .new_game(new_game), .an(an), .seg(seg), .dp(dp), .game_over(game_over), .winner(winner)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int         n;
    logic       p1, p2, ng;
    logic [7:0] exp_p1, exp_p2;
    logic       exp_go, exp_win;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return (d < 4'd10) ? tbl[d] : 7'b1111111;
  endfunction

  function automatic logic [6:0] exp_tens(input logic [3:0] d);
`ifdef SCORE_BLANK_LZ_EN
    if (d == 4'd0) return 7'b1111111;
`endif
    return exp_seg(d);
  endfunction

  function automatic logic [27:0] exp_disp(input logic [7:0] s1, input logic [7:0] s2);
    return {exp_tens(s1[7:4]), exp_seg(s1[3:0]), exp_tens(s2[7:4]), exp_seg(s2[3:0])};
  endfunction

  task automatic scan_pulse();
    scan_clk = 1'b1;
    repeat (4) tick();
    scan_clk = 1'b0;
    repeat (4) tick();
  endtask

  // Step through all four digits, filing each seg value under the anode that is low
  task automatic read_display(output logic [27:0] got);
    got = '0;
    for (int k = 0; k < 4; k++) begin
      scan_pulse();
      case (an)
        4'b0111: got[27:21] = seg;
        4'b1011: got[20:14] = seg;
        4'b1101: got[13:7]  = seg;
        4'b1110: got[6:0]   = seg;
        default: got = 28'hFFFFFFF;
      endcase
    end
  endtask

  task automatic pulse(input logic p1, input logic p2, input logic ng);
    point_p1 = p1; point_p2 = p2; new_game = ng;
    tick();
    point_p1 = 1'b0; point_p2 = 1'b0; new_game = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [27:0] disp;
    logic [3:0]  an_steps [4];
    an_steps = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    rst = 1'b1; scan_clk = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0; new_game = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_an", 32'(an), 32'(4'b1110));
    check("reset_seg", 32'(seg), 32'(7'b0000001));
    check("reset_dp", 32'(dp), 32'd1);
    check("reset_game_over", 32'(game_over), 32'd0);
    check("reset_winner", 32'(winner), 32'd0);

    // Scan latency: idx moves on the 3rd edge after scan_clk rises, display on the 4th
    for (int s = 0; s < 4; s++) begin
      scan_clk = 1'b1;
      repeat (3) tick();
      check("scan_an_before", 32'(an), (s == 0) ? 32'(4'b1110) : 32'(an_steps[s-1]));
      tick();
      check("scan_an_step", 32'(an), 32'(an_steps[s]));
      check("scan_dp", 32'(dp), (an_steps[s] == 4'b1011) ? 32'd0 : 32'd1);
      repeat (4) tick();
      check("scan_hold", 32'(an), 32'(an_steps[s]));
      scan_clk = 1'b0;
      repeat (3) tick();
    end

    vecs.push_back('{1,  1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1,  1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{9,  1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{10, 1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 1'b0, 8'h10, 8'h11, 1'b1, 1'b1});
    vecs.push_back('{1,  1'b1, 1'b0, 1'b0, 8'h10, 8'h11, 1'b1, 1'b1});
    vecs.push_back('{1,  1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{7,  1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{4,  1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{3,  1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0});
    vecs.push_back('{1,  1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{9,  1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0});

    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++) pulse(vecs[v].p1, vecs[v].p2, vecs[v].ng);
      check($sformatf("vec%0d_game_over", v), 32'(game_over), 32'(vecs[v].exp_go));
      if (vecs[v].exp_go) check($sformatf("vec%0d_winner", v), 32'(winner), 32'(vecs[v].exp_win));
      read_display(disp);
      check($sformatf("vec%0d_display", v), 32'(disp), 32'(exp_disp(vecs[v].exp_p1, vecs[v].exp_p2)));
    end

    // Mid-game reset discards scores and scan position
    pulse(1'b1, 1'b0, 1'b0);
    scan_pulse();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("midreset_an", 32'(an), 32'(4'b1110));
    check("midreset_seg", 32'(seg), 32'(7'b0000001));
    check("midreset_dp", 32'(dp), 32'd1);
    check("midreset_game_over", 32'(game_over), 32'd0);
    read_display(disp);
    check("midreset_display", 32'(disp), 32'(exp_disp(8'h00, 8'h00)));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
